// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: holds the PC, requests one word at a time from
// instruction memory and presents it to decode, with single-cycle redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_take,
  input  logic [31:0] in_target,
  input  logic        in_stall,
  input  logic        in_imem_ready,
  input  logic [31:0] in_imem_rdata,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  output logic        out_instr_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus,
  output logic        out_flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic        r_flush;
  logic [31:0] w_pc_plus;

  // Natural 32-bit addition gives the silent wrap at the top of the space.
  assign w_pc_plus       = r_pc + PC_INC;
  assign out_imem_addr   = r_pc;
  assign out_pc          = r_pc;
  assign out_pc_plus     = w_pc_plus;
  assign out_imem_req    = r_req;
  assign out_instr_valid = r_valid;
  assign out_instr       = r_instr;
  assign out_flush       = r_flush;

  // Fetch FSM; req/valid are registered alongside the next state so they never overlap.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      if (in_take) begin
        // Redirect wins over stall and any same-cycle memory return.
        r_pc    <= in_target;
        r_valid <= 1'b0;
        r_flush <= 1'b1;
        r_req   <= 1'b1;
        r_state <= FETCH;
      end else begin
        case (r_state)
          IDLE: begin
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
          FETCH: begin
            if (in_imem_ready) begin
              r_instr <= in_imem_rdata;
              r_valid <= 1'b1;
              r_req   <= 1'b0;
              r_state <= VALID;
            end else begin
              r_req   <= 1'b1;
              r_state <= FETCH;
            end
          end
          VALID: begin
            if (in_stall) begin
              r_req   <= 1'b0;
              r_state <= VALID;
            end else begin
              r_pc    <= w_pc_plus;
              r_valid <= 1'b0;
              r_req   <= 1'b1;
              r_state <= FETCH;
            end
          end
          default: begin
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven, scoreboarded bench for pc_fetch_unit plus hand-written reset sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        take;
  logic [31:0] target;
  logic        stall;
  logic        ready;
  logic [31:0] rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        flush;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        take;
    logic [31:0] tgt;
    logic        stall;
    logic        ready;
    logic [31:0] rdata;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
  } vec_t;

  typedef struct {
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        flush;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  pc_fetch_unit dut (
    .in_clk          (clk),
    .in_rst_n        (rst_n),
    .in_take         (take),
    .in_target       (target),
    .in_stall        (stall),
    .in_imem_ready   (ready),
    .in_imem_rdata   (rdata),
    .out_imem_req    (imem_req),
    .out_imem_addr   (imem_addr),
    .out_instr_valid (instr_valid),
    .out_instr       (instr),
    .out_pc          (pc),
    .out_pc_plus     (pc_plus),
    .out_flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic tk, input logic [31:0] tg, input logic st, input logic rd,
                     input logic [31:0] dat, input logic e_req, input logic e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_flush);
    vec_t v;
    v.take = tk; v.tgt = tg; v.stall = st; v.ready = rd; v.rdata = dat;
    v.req = e_req; v.valid = e_valid; v.instr = e_instr; v.pc = e_pc; v.flush = e_flush;
    vecs.push_back(v);
  endtask

  task automatic compare_front(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty v%0d: got 0 entries expected 1", idx);
    end else begin
      e = sb.pop_front();
      chk1 ($sformatf("v%0d.req", idx),     imem_req,    e.req);
      chk1 ($sformatf("v%0d.valid", idx),   instr_valid, e.valid);
      chk32($sformatf("v%0d.instr", idx),   instr,       e.instr);
      chk32($sformatf("v%0d.pc", idx),      pc,          e.pc);
      chk32($sformatf("v%0d.addr", idx),    imem_addr,   e.pc);
      chk32($sformatf("v%0d.pc_plus", idx), pc_plus,     e.pc_plus);
      chk1 ($sformatf("v%0d.flush", idx),   flush,       e.flush);
      chk1 ($sformatf("v%0d.excl", idx),    instr_valid & imem_req, 1'b0);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    take = v.take; target = v.tgt; stall = v.stall; ready = v.ready; rdata = v.rdata;
    e.req = v.req; e.valid = v.valid; e.instr = v.instr; e.pc = v.pc;
    e.pc_plus = v.pc + 32'd1;
    e.flush = v.flush;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front(idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; take = 1'b0; target = 32'd0; stall = 1'b0; ready = 1'b1; rdata = 32'hDEAD_0000;

    // Fields: take tgt stall ready rdata | req valid instr pc flush
    // Sequential fetch 0..3 (starting in FETCH at pc 0)
    add(0, 32'h0, 0, 1, 32'hA000_0000, 0, 1, 32'hA000_0000, 32'h0, 0);
    add(0, 32'h0, 0, 0, 32'h0,         1, 0, 32'hA000_0000, 32'h1, 0);
    add(0, 32'h0, 0, 1, 32'hA000_0001, 0, 1, 32'hA000_0001, 32'h1, 0);
    add(0, 32'h0, 0, 0, 32'h0,         1, 0, 32'hA000_0001, 32'h2, 0);
    add(0, 32'h0, 0, 1, 32'hA000_0002, 0, 1, 32'hA000_0002, 32'h2, 0);
    add(0, 32'h0, 0, 0, 32'h0,         1, 0, 32'hA000_0002, 32'h3, 0);
    add(0, 32'h0, 0, 0, 32'hBAD0_0003, 1, 0, 32'hA000_0002, 32'h3, 0);
    add(0, 32'h0, 0, 1, 32'hA000_0003, 0, 1, 32'hA000_0003, 32'h3, 0);
    // Stall hold at pc 5
    add(1, 32'h5, 1, 0, 32'h0,         1, 0, 32'hA000_0003, 32'h5, 1);
    add(0, 32'h0, 0, 1, 32'hA000_0005, 0, 1, 32'hA000_0005, 32'h5, 0);
    add(0, 32'h0, 1, 1, 32'hBAD0_0001, 0, 1, 32'hA000_0005, 32'h5, 0);
    add(0, 32'h0, 1, 1, 32'hBAD0_0002, 0, 1, 32'hA000_0005, 32'h5, 0);
    add(0, 32'h0, 1, 0, 32'hBAD0_0003, 0, 1, 32'hA000_0005, 32'h5, 0);
    add(0, 32'h0, 0, 0, 32'h0,         1, 0, 32'hA000_0005, 32'h6, 0);
    // Redirect to 8, then redirect/ready collision at pc 8
    add(1, 32'h8, 0, 0, 32'h0,         1, 0, 32'hA000_0005, 32'h8, 1);
    add(1, 32'h40, 0, 1, 32'hBAD0_0008, 1, 0, 32'hA000_0005, 32'h40, 1);
    add(0, 32'h0, 0, 0, 32'h0,         1, 0, 32'hA000_0005, 32'h40, 0);
    // Taken branch during stall
    add(0, 32'h0, 0, 1, 32'hB000_0040, 0, 1, 32'hB000_0040, 32'h40, 0);
    add(1, 32'h100, 1, 0, 32'h0,       1, 0, 32'hB000_0040, 32'h100, 1);
    // Wrap at top of address space
    add(1, 32'hFFFF_FFFF, 0, 0, 32'h0, 1, 0, 32'hB000_0040, 32'hFFFF_FFFF, 1);
    add(0, 32'h0, 0, 1, 32'hC000_0000, 0, 1, 32'hC000_0000, 32'hFFFF_FFFF, 0);
    add(0, 32'h0, 0, 0, 32'h0,         1, 0, 32'hC000_0000, 32'h0, 0);
    // Back-to-back redirects: last target wins, each cycle flushes
    add(1, 32'h10, 0, 0, 32'h0,        1, 0, 32'hC000_0000, 32'h10, 1);
    add(1, 32'h20, 0, 0, 32'h0,        1, 0, 32'hC000_0000, 32'h20, 1);
    add(0, 32'h0, 0, 0, 32'h0,         1, 0, 32'hC000_0000, 32'h20, 0);

    // Reset state while held, with a ready pulse present
    #3;
    chk1 ("rst.req",   imem_req,    1'b0);
    chk1 ("rst.valid", instr_valid, 1'b0);
    chk32("rst.instr", instr,       32'h0);
    chk32("rst.addr",  imem_addr,   32'h0);
    chk1 ("rst.flush", flush,       1'b0);
    #1;
    rst_n = 1'b0;
    ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1 ("rel.req",   imem_req,    1'b1);
    chk1 ("rel.valid", instr_valid, 1'b0);
    chk32("rel.addr",  imem_addr,   32'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset mid-FETCH at pc 0x20 with a ready pulse during reset
    @(negedge clk);
    ready = 1'b1; rdata = 32'hBAD0_0020;
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("arst.req",   imem_req,    1'b0);
    chk32("arst.addr",  imem_addr,   32'h0);
    chk1 ("arst.valid", instr_valid, 1'b0);
    chk32("arst.instr", instr,       32'h0);
    @(posedge clk);
    #1;
    chk1 ("arst_hold.req",   imem_req,    1'b0);
    chk1 ("arst_hold.valid", instr_valid, 1'b0);
    chk32("arst_hold.addr",  imem_addr,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1 ("arel.req",   imem_req,    1'b1);
    chk1 ("arel.valid", instr_valid, 1'b0);
    chk32("arel.addr",  imem_addr,   32'h0);
    @(posedge clk);
    #1;
    chk1 ("arel2.valid", instr_valid, 1'b1);
    chk32("arel2.instr", instr,       32'hBAD0_0020);
    chk32("arel2.pc",    pc,          32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 SHALL have parameter PC_INC, default 32'd1, which is the sequential PC increment (word-addressed instruction memory).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- in_clk  input  1  rising-edge clock.
- in_rst_n  input  1  asynchronous active-low reset.
- in_take  input  1  branch/jump taken; this is the branch-decision output of the PC control logic.
- in_target  input  32  redirect target, valid when in_take=1.
- in_stall  input  1  decode stall; 1 = held instruction not accepted this cycle.
- in_imem_ready  input  1  instruction memory returns in_imem_rdata this cycle.
- in_imem_rdata  input  32  fetched instruction word.
- out_imem_req  output  1  fetch request.
- out_imem_addr  output  32  fetch address; equals the current PC.
- out_instr_valid  output  1  out_instr/out_pc hold a valid instruction.
- out_instr  output  32  held instruction word.
- out_pc  output  32  PC of the held instruction.
- out_pc_plus  output  32  out_pc + PC_INC, for link and return use.
- out_flush  output  1  one-cycle pulse: the younger pipeline stages are squashed.

Function
REQ-005 SHALL implement a 3-state FSM with states IDLE, FETCH and VALID.
REQ-006 SHALL hold internal register pc; out_imem_addr=pc and out_pc=pc combinationally.
REQ-007 SHALL move IDLE to FETCH unconditionally one cycle after reset deassertion; out_imem_req=0 in IDLE.
REQ-008 SHALL drive out_imem_req=1 in FETCH, and on a cycle with in_imem_ready=1 and in_take=0:
- register out_instr<=in_imem_rdata;
- set out_instr_valid<=1;
- move to VALID;
- leave pc unchanged.
REQ-009 SHALL keep FETCH, pc and out_imem_req=1 stable while in_imem_ready=0.
REQ-010 SHALL, in VALID with in_stall=1 and in_take=0, hold out_instr, out_pc and out_instr_valid=1 unchanged; out_imem_req=0.
REQ-011 SHALL, in VALID with in_stall=0 and in_take=0, accept the instruction:
- pc<=pc+PC_INC;
- out_instr_valid<=0;
- move to FETCH.
REQ-012 SHALL compute pc+PC_INC modulo 2^32: 32'hFFFF_FFFF + 1 wraps to 32'h0000_0000 silently.
REQ-013 SHALL give in_take=1 in any state priority over in_stall and in_imem_ready:
- pc<=in_target;
- out_instr_valid<=0;
- out_flush<=1 for exactly the next cycle;
- next state FETCH.
REQ-014 SHALL discard in_imem_rdata when in_take=1 and in_imem_ready=1 fall in the same FETCH cycle; out_instr is not updated.
REQ-015 SHALL give redirect latency of exactly one cycle: in_take sampled at edge N gives out_imem_addr=in_target from edge N+1.
REQ-016 SHALL redirect on every cycle of back-to-back in_take; each such cycle produces an out_flush pulse, and the last target wins.
REQ-017 SHALL compute out_pc_plus combinationally from pc with the same wrap rule.
REQ-018 SHALL never assert out_instr_valid and out_imem_req in the same cycle.

Reset
REQ-019 SHALL, on in_rst_n=0, immediately (asynchronously) set:
- pc=RESET_PC;
- state=IDLE;
- out_imem_req=0, out_instr_valid=0, out_instr=0, out_flush=0.
REQ-020 SHALL, on reset mid-fetch or mid-stall, abandon any outstanding fetch; an in_imem_ready pulse arriving during reset is ignored.
REQ-021 SHALL hold reset values while in_rst_n=0 and leave IDLE on the first rising edge after release.

Verification
REQ-022 SHALL cover sequential fetch: release reset; in_imem_ready=1 every FETCH cycle; in_stall=0 -> out_pc sequence 0,1,2,3; out_instr_valid high every other cycle.
REQ-023 SHALL cover stall hold: in VALID with out_pc=5, in_stall=1 for 3 cycles -> out_instr and out_pc=5 unchanged and out_imem_req=0; on release, out_imem_addr=6 the next cycle.
REQ-024 SHALL cover redirect vs ready collision: in FETCH at pc=8, in_take=1, in_target=0x40, in_imem_ready=1 in the same cycle -> rdata dropped, out_flush=1 for one cycle, out_imem_addr=0x40 next cycle.
REQ-025 SHALL cover taken branch during stall: VALID, in_stall=1, in_take=1, in_target=0x100 -> out_instr_valid=0 and out_imem_addr=0x100 next cycle.
REQ-026 SHALL cover wrap: in_take with in_target=32'hFFFF_FFFF, fetch, accept -> next out_imem_addr=0, out_pc_plus=0 while holding 0xFFFF_FFFF.
REQ-027 SHALL cover asynchronous reset: assert in_rst_n=0 mid-FETCH at pc=0x20 -> out_imem_req=0 and pc=RESET_PC before the next edge; no stale out_instr_valid after release.
